// File: rtl/chg_recorder_pkg.sv
// Shared types and helpers for the change recorder.
package chg_recorder_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/chg_recorder_if.sv
// Event stream from the recorder to its consumer, plus occupancy/status.
interface chg_recorder_if #(
  parameter int unsigned TS_W    = 16,
  parameter int unsigned LEVEL_W = 3
);
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_value;
  logic [TS_W-1:0]   evt_time;
  logic [LEVEL_W-1:0] level;
  logic              overflow;

  modport master (
    output evt_valid, evt_value, evt_time, level, overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_value, evt_time, level, overflow,
    output evt_ready
  );
endinterface

// File: rtl/chg_fifo.sv
// First-word fall-through FIFO; full/empty derived from the occupancy count.
module chg_fifo
  import chg_recorder_pkg::*;
#(
  parameter  int unsigned WIDTH = 17,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = clog2(DEPTH),
  localparam int unsigned LW    = clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             pop_ok_c;
  logic             push_ok_c;

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign rdata     = mem[rd_ptr];
  assign pop_ok_c  = pop & ~empty;
  // A pop at the same edge frees the slot a full FIFO would otherwise lack.
  assign push_ok_c = push & (~full | pop_ok_c);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; it is unobservable while empty.
  always_ff @(posedge clock) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/chg_recorder.sv
// Timestamps every change of din and queues {value, time} events.
module chg_recorder
  import chg_recorder_pkg::*;
#(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  chg_recorder_if.master evt
);

  state_t          state;
  state_t          state_nxt;
  logic [TS_W-1:0] ts;
  logic            din_q;
  logic            overflow;
  logic            push_c;
  logic            pop_c;
  logic            full;
  logic            empty;
  logic [TS_W:0]   head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  // INIT only captures the first sample; changes are reported once armed.
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    case (state)
      INIT:    state_nxt = ARMED;
      ARMED:   push_c    = (din != din_q);
      default: state_nxt = INIT;
    endcase
  end

  assign pop_c = ~empty & evt.evt_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts       <= '0;
      din_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ts    <= ts + TS_W'(1);
      din_q <= din;
      if (push_c && full && !pop_c) overflow <= 1'b1;
    end
  end

  chg_fifo #(
    .WIDTH (TS_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   ({din, ts}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (evt.level)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_value = head[TS_W];
  assign evt.evt_time  = head[TS_W-1:0];
  assign evt.overflow  = overflow;

endmodule

// File: tb/tb_chg_recorder.sv
// Directed bench for chg_recorder: arming, latency, backpressure, wrap, reset.
module tb_chg_recorder;
  import chg_recorder_pkg::*;

  localparam int unsigned LW = clog2(4) + 1;

  logic clock;
  logic reset_n;
  logic din;
  logic reset_n2;
  logic din2;

  int vectors;
  int miscompares;

  chg_recorder_if #(.TS_W(16), .LEVEL_W(LW)) bus ();
  chg_recorder_if #(.TS_W(4),  .LEVEL_W(LW)) bus2 ();

  chg_recorder #(.TS_W(16), .DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (din),
    .evt     (bus.master)
  );

  chg_recorder #(.TS_W(4), .DEPTH(4)) dut2 (
    .clock   (clock),
    .reset_n (reset_n2),
    .din     (din2),
    .evt     (bus2.master)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge where reset is released; next edge is the INIT edge.
  task automatic do_reset(input logic d);
    @(negedge clock);
    reset_n       = 1'b0;
    din           = d;
    bus.evt_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name, input logic [16:0] expv [4]);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bus.evt_valid, bus.evt_value, bus.evt_time} !== {1'b1, expv[i]}) begin
        miscompares++;
        $display("FAIL %s[%0d]: got v=%0b val=%0b t=%0d, want v=1 val=%0b t=%0d",
                 name, i, bus.evt_valid, bus.evt_value, bus.evt_time, expv[i][16], expv[i][15:0]);
      end
      bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
    end
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.level !== LW'(0)) begin
      miscompares++;
      $display("FAIL %s_empty: got v=%0b level=%0d, want v=0 level=0", name, bus.evt_valid, bus.level);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    vectors++;
    if (bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %0b want 0", bus.evt_valid);
    end
    vectors++;
    if (bus.level !== LW'(0)) begin
      miscompares++;
      $display("FAIL reset_level: got %0d want 0", bus.level);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overflow: got %0b want 0", bus.overflow);
    end
  endtask

  task automatic test_arming();
    din     = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (bus.evt_valid !== 1'b0 || bus.level !== LW'(0)) begin
        miscompares++;
        $display("FAIL arming[%0d]: got v=%0b level=%0d, want v=0 level=0", i, bus.evt_valid, bus.level);
      end
    end
  endtask

  task automatic test_single_edge();
    do_reset(1'b0);
    bus.evt_ready = 1'b1;
    repeat (5) step();
    din = 1'b1;
    step();
    vectors++;
    if ({bus.evt_valid, bus.evt_value, bus.evt_time, bus.level} !== {1'b1, 1'b1, 16'd5, LW'(1)}) begin
      miscompares++;
      $display("FAIL single_edge: got v=%0b val=%0b t=%0d level=%0d, want 1 1 5 1",
               bus.evt_valid, bus.evt_value, bus.evt_time, bus.level);
    end
    step();
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.level !== LW'(0)) begin
      miscompares++;
      $display("FAIL single_pop: got v=%0b level=%0d, want v=0 level=0", bus.evt_valid, bus.level);
    end
  endtask

  task automatic test_overflow();
    logic [16:0] expv [4];
    expv = '{{1'b1, 16'd1}, {1'b0, 16'd2}, {1'b1, 16'd3}, {1'b0, 16'd4}};
    do_reset(1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      step();
    end
    vectors++;
    if (bus.level !== LW'(4) || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flags: got level=%0d ovf=%0b, want level=4 ovf=1", bus.level, bus.overflow);
    end
    repeat (2) step();
    vectors++;
    if ({bus.evt_valid, bus.evt_value, bus.evt_time} !== {1'b1, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL overflow_hold: got v=%0b val=%0b t=%0d, want 1 1 1",
               bus.evt_valid, bus.evt_value, bus.evt_time);
    end
    drain("overflow_drain", expv);
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %0b want 1", bus.overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [16:0] expv [4];
    expv = '{{1'b0, 16'd2}, {1'b1, 16'd3}, {1'b0, 16'd4}, {1'b1, 16'd5}};
    do_reset(1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      din = ~din;
      step();
    end
    vectors++;
    if (bus.level !== LW'(4) || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_fill: got level=%0d ovf=%0b, want level=4 ovf=0", bus.level, bus.overflow);
    end
    din           = ~din;
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    vectors++;
    if (bus.level !== LW'(4) || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_push: got level=%0d ovf=%0b, want level=4 ovf=0", bus.level, bus.overflow);
    end
    drain("full_pop_drain", expv);
  endtask

  task automatic test_wrap();
    @(negedge clock);
    reset_n2       = 1'b0;
    din2           = 1'b0;
    bus2.evt_ready = 1'b1;
    step();
    reset_n2 = 1'b1;
    repeat (15) step();
    din2 = 1'b1;
    step();
    vectors++;
    if ({bus2.evt_valid, bus2.evt_value, bus2.evt_time} !== {1'b1, 1'b1, 4'd15}) begin
      miscompares++;
      $display("FAIL wrap_first: got v=%0b val=%0b t=%0d, want 1 1 15",
               bus2.evt_valid, bus2.evt_value, bus2.evt_time);
    end
    step();
    din2 = 1'b0;
    step();
    vectors++;
    if ({bus2.evt_valid, bus2.evt_value, bus2.evt_time} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL wrap_second: got v=%0b val=%0b t=%0d, want 1 0 1",
               bus2.evt_valid, bus2.evt_value, bus2.evt_time);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus2.evt_valid !== 1'b0 || bus2.level !== LW'(0)) begin
        miscompares++;
        $display("FAIL wrap_extra[%0d]: got v=%0b level=%0d, want v=0 level=0", i, bus2.evt_valid, bus2.level);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      step();
    end
    vectors++;
    if (bus.level !== LW'(3)) begin
      miscompares++;
      $display("FAIL mid_fill: got level=%0d want 3", bus.level);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.level !== LW'(0) || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: got v=%0b level=%0d ovf=%0b, want 0 0 0",
               bus.evt_valid, bus.level, bus.overflow);
    end
    step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.level !== LW'(0)) begin
      miscompares++;
      $display("FAIL mid_no_stale: got v=%0b level=%0d, want v=0 level=0", bus.evt_valid, bus.level);
    end
    repeat (2) step();
    din = 1'b0;
    step();
    vectors++;
    if ({bus.evt_valid, bus.evt_value, bus.evt_time, bus.level} !== {1'b1, 1'b0, 16'd3, LW'(1)}) begin
      miscompares++;
      $display("FAIL mid_restart: got v=%0b val=%0b t=%0d level=%0d, want 1 0 3 1",
               bus.evt_valid, bus.evt_value, bus.evt_time, bus.level);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    clock          = 1'b0;
    reset_n        = 1'b0;
    din            = 1'b1;
    bus.evt_ready  = 1'b0;
    reset_n2       = 1'b0;
    din2           = 1'b0;
    bus2.evt_ready = 1'b0;
    test_reset();
    test_arming();
    test_single_edge();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chg_recorder.md
CHG_RECORDER -- requirements
Module: chg_recorder

Interface
REQ-001 SHALL have parameter TS_W, default 16: timestamp width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, power of two and at least 2: event FIFO entries.
REQ-003 SHALL have port clock, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port din, input, 1: monitored signal, synchronous to clock.
REQ-006 SHALL have port evt_valid, output, 1: head event present.
REQ-007 SHALL have port evt_ready, input, 1: consumer accepts head event.
REQ-008 SHALL have port evt_value, output, 1: new din value of head event.
REQ-009 SHALL have port evt_time, output, TS_W: timestamp of head event.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1: FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when an event is dropped.

Function
REQ-012 SHALL implement a free-running counter ts, TS_W bits, +1 every clock, wrapping from all-ones to 0.
REQ-013 SHALL register din each edge into din_q.
REQ-014 SHALL use two states: INIT (no valid din_q yet) and ARMED.
REQ-015 SHALL go from INIT to ARMED at the first edge after reset release, loading din_q and pushing no event.
REQ-016 SHALL, in ARMED at edge k, detect a change when din differs from din_q, and push {din, ts value just before edge k}.
REQ-017 SHALL present a pushed event on evt_valid/evt_value/evt_time in the cycle after edge k when the FIFO was empty (first-word fall-through, latency 1).
REQ-018 SHALL pop the head at an edge where evt_valid and evt_ready are both 1, and SHALL keep the head stable while evt_valid=1 and evt_ready=0.
REQ-019 SHALL make evt_value and evt_time don't-care while evt_valid=0, with the bench checking them only when valid.
REQ-020 SHALL, on a push with FIFO full and no pop at the same edge, drop the event, leave FIFO contents unchanged and set overflow.
REQ-021 SHALL, on a push and pop at the same edge with FIFO full, accept the push with level unchanged and overflow not set.
REQ-022 SHALL, on a push and pop at the same edge with FIFO empty, accept the push (no bypass of the pop) and give level 1 next cycle.
REQ-023 SHALL hold overflow at 1 until reset.
REQ-024 SHALL make level equal to the number of stored entries, updated at the same edge as the push/pop, and never exceeding DEPTH.
REQ-025 SHALL use FIFO pointers of clog2(DEPTH) bits wrapping modulo DEPTH, with full/empty decided from the occupancy count.

Reset
REQ-026 SHALL, on reset_n=0 at any time including mid-stream, asynchronously force: state=INIT, ts=0, din_q=0, read/write pointers=0, level=0, evt_valid=0, overflow=0.
REQ-027 SHALL discard all pending events on reset, with none reappearing after release.
REQ-028 SHALL not reset FIFO storage RAM, which is not observable while level=0.

Structure
REQ-029 SHALL place the state enum (INIT, ARMED) and a clog2 helper function in a shared package chg_recorder_pkg.
REQ-030 SHALL implement the FIFO as one sub-module chg_fifo (parameters WIDTH=TS_W+1 and DEPTH) with push/pop/full/empty/level ports.
REQ-031 SHALL keep change detection, ts and overflow logic in chg_recorder.

Verification
REQ-032 SHALL verify arming: release reset with din=1 held -> no event; evt_valid=0 and level=0 for 20 cycles.
REQ-033 SHALL verify single edge: din 0->1 sampled at the edge where ts was 5, evt_ready=1 -> one event {value=1, time=5} visible one cycle later, level returns to 0.
REQ-034 SHALL verify backpressure/overflow: evt_ready=0, din toggled every cycle for 6 changes, DEPTH=4 -> level=4, overflow=1, the four retained events carry consecutive timestamps, and draining yields exactly those four in order.
REQ-035 SHALL verify full with simultaneous pop: FIFO full, evt_ready=1 for one edge while a change occurs -> level stays 4, overflow stays 0, and the new event is last in drain order.
REQ-036 SHALL verify wrap: TS_W=4, change when ts=15 and next change when ts=1 -> times 15 then 1, with no extra events.
REQ-037 SHALL verify reset mid-operation: level=3, assert reset_n=0 for 1 cycle -> evt_valid=0, level=0, overflow=0 immediately; after release the first change reports a time counted from 0.
